// File: rtl/spu_fwd_pkg.sv
// Shared types and helpers for the SPU result-staging / forwarding network.
package spu_fwd_pkg;

    localparam int unsigned FWD_DATA_W = 128;
    localparam int unsigned FWD_ADDR_W = 7;
    localparam int unsigned FWD_LAT_W  = 3;

    // One staged result: target register, value and declared latency.
    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] rt;
        logic [FWD_DATA_W-1:0] data;
        logic [FWD_LAT_W-1:0]  lat;
    } fwd_entry_t;

    // Latency 0 behaves as 1; anything beyond the pipe depth saturates at the depth.
    function automatic logic [FWD_LAT_W-1:0] clamp_lat(input logic [FWD_LAT_W-1:0] lat,
                                                       input int unsigned depth);
        logic [FWD_LAT_W-1:0] r;
        if (lat == '0)
            r = FWD_LAT_W'(1);
        else if (32'(lat) > depth)
            r = FWD_LAT_W'(depth);
        else
            r = lat;
        return r;
    endfunction

endpackage

// File: rtl/spu_fwd_lookup.sv
// Priority match of one source operand against every staged entry.
import spu_fwd_pkg::*;

module spu_fwd_lookup #(
    parameter int unsigned NPIPE  = 2,
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned ADDR_W = FWD_ADDR_W,
    parameter int unsigned DATA_W = FWD_DATA_W
) (
    input  fwd_entry_t [DEPTH-1:0][NPIPE-1:0] i_stage,
    input  logic [ADDR_W-1:0]                 i_addr,
    output logic                              o_hit,
    output logic                              o_stall,
    output logic [DATA_W-1:0]                 o_data
);

    logic              w_found;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;

    // Scan oldest stage first and lowest pipe first so the last match written
    // is the youngest (lowest stage, highest pipe) one.
    always_comb begin
        w_found = 1'b0;
        w_ready = 1'b0;
        w_data  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            for (int unsigned p = 0; p < NPIPE; p++) begin
                if (i_stage[DEPTH-1-k][p].valid && (i_stage[DEPTH-1-k][p].rt == i_addr)) begin
                    w_found = 1'b1;
                    w_ready = (32'(i_stage[DEPTH-1-k][p].lat) <= (DEPTH - k));
                    w_data  = i_stage[DEPTH-1-k][p].data;
                end
            end
        end
    end

    // An unready youngest match blocks any older ready value.
    always_comb begin
        o_hit   = w_found & w_ready;
        o_stall = w_found & ~w_ready;
        o_data  = (w_found & w_ready) ? w_data : '0;
    end

endmodule

// File: rtl/spu_fwd_network.sv
// Result staging shift register, flush/reset masking, forwarding lookups and
// register-file writeback taps for NPIPE issue pipes.
import spu_fwd_pkg::*;

module spu_fwd_network #(
    parameter int unsigned DATA_W      = FWD_DATA_W,
    parameter int unsigned ADDR_W      = FWD_ADDR_W,
    parameter int unsigned NPIPE       = 2,
    parameter int unsigned DEPTH       = 7,
    parameter int unsigned NSRC        = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned LAT_W       = FWD_LAT_W
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NPIPE-1:0]                        in_valid,
    input  logic [NPIPE-1:0][ADDR_W-1:0]            in_rt,
    input  logic [NPIPE-1:0][DATA_W-1:0]            in_data,
    input  logic [NPIPE-1:0][LAT_W-1:0]             in_lat,
    input  logic                                    flush,
    input  logic [NPIPE-1:0][NSRC-1:0][ADDR_W-1:0]  src_addr,
    output logic [NPIPE-1:0][NSRC-1:0]              fwd_hit,
    output logic [NPIPE-1:0][NSRC-1:0][DATA_W-1:0]  fwd_data,
    output logic [NPIPE-1:0][NSRC-1:0]              fwd_stall,
    output logic [NPIPE-1:0]                        wb_valid,
    output logic [NPIPE-1:0][ADDR_W-1:0]            wb_rt,
    output logic [NPIPE-1:0][DATA_W-1:0]            wb_data
);

    fwd_entry_t [DEPTH-1:0][NPIPE-1:0] r_stage;

    // Shift every stage each edge; flush kills the youngest stages, reset kills all valids.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                for (int unsigned p = 0; p < NPIPE; p++) begin
                    r_stage[k][p].valid <= 1'b0;
                end
            end
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                if (flush && (k < FLUSH_DEPTH)) begin
                    for (int unsigned p = 0; p < NPIPE; p++) begin
                        r_stage[k][p].valid <= 1'b0;
                    end
                end
            end
            for (int unsigned p = 0; p < NPIPE; p++) begin
                r_stage[0][p] <= '{valid: in_valid[p] & ~flush,
                                   rt:    in_rt[p],
                                   data:  in_data[p],
                                   lat:   clamp_lat(in_lat[p], DEPTH)};
            end
        end
    end

    // Writeback mirrors the last stage directly from registers.
    always_comb begin
        for (int unsigned p = 0; p < NPIPE; p++) begin
            wb_valid[p] = r_stage[DEPTH-1][p].valid;
            wb_rt[p]    = r_stage[DEPTH-1][p].rt;
            wb_data[p]  = r_stage[DEPTH-1][p].data;
        end
    end

    for (genvar gp = 0; gp < NPIPE; gp++) begin : g_pipe
        for (genvar gs = 0; gs < NSRC; gs++) begin : g_src
            spu_fwd_lookup #(
                .NPIPE (NPIPE),
                .DEPTH (DEPTH),
                .ADDR_W(ADDR_W),
                .DATA_W(DATA_W)
            ) u_lookup (
                .i_stage(r_stage),
                .i_addr (src_addr[gp][gs]),
                .o_hit  (fwd_hit[gp][gs]),
                .o_stall(fwd_stall[gp][gs]),
                .o_data (fwd_data[gp][gs])
            );
        end
    end

endmodule

// File: doc/spu_fwd_network.md
# spu_fwd_network

Parametrised result-staging and operand-forwarding network for the dual-issue SPU datapath, generalising the fixed even/odd forwarding macro to NPIPE issue pipes, DEPTH staging stages and NSRC source operands per pipe. Every issued result enters a shift-register pipeline carrying its target address, data and declared latency. The network answers per-operand forwarding lookups with hit, data and stall, supports branch flush of the youngest stages, and drives register-file writeback from the last stage.

## Interface
- DATA_W, 128, result/operand width
- ADDR_W, 7, register address width (128 registers)
- NPIPE, 2, issue pipes; pipe 0 = even, pipe 1 = odd; a higher index is later in program order
- DEPTH, 7, staging stages (stage 0 youngest, stage DEPTH-1 = writeback)
- NSRC, 3, source operands per pipe (RA, RB, RC)
- FLUSH_DEPTH, 2, stages cleared by flush (1..DEPTH)
- LAT_W, 3, latency field width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled 0 at posedge clears all state
- in_valid  in  [NPIPE]  issue valid per pipe
- in_rt  in  [NPIPE][ADDR_W]  target register
- in_data  in  [NPIPE][DATA_W]  result value
- in_lat  in  [NPIPE][LAT_W]  result latency in cycles
- flush  in  1  branch-taken kill
- src_addr  in  [NPIPE][NSRC][ADDR_W]  lookup addresses
- fwd_hit  out  [NPIPE][NSRC]  a ready matching entry was found
- fwd_data  out  [NPIPE][NSRC][DATA_W]  forwarded value, 0 when no hit
- fwd_stall  out  [NPIPE][NSRC]  youngest matching entry is not yet ready
- wb_valid  out  [NPIPE]  writeback strobe
- wb_rt  out  [NPIPE][ADDR_W]  writeback address
- wb_data  out  [NPIPE][DATA_W]  writeback data

## Operation
- Entry = {valid, rt, data, lat}. Every edge: stage k+1 <= stage k for k < DEPTH-1; stage 0 <= {in_valid, in_rt, in_data, clamp(in_lat)} per pipe. Stage DEPTH-1 contents are discarded after writeback.
- Latency clamp: lat 0 is treated as 1; lat > DEPTH is treated as DEPTH.
- An entry in stage i is ready iff lat <= i+1.
- Lookup, per (pipe p, source s): scan valid entries across all stages and pipes whose rt == src_addr[p][s].
  - Selection: the lowest stage index wins; within a stage, the highest pipe index wins.
  - If the selected entry is ready: fwd_hit=1, fwd_data=data, fwd_stall=0.
  - If the selected entry is not ready: fwd_stall=1, fwd_hit=0, fwd_data=0. An older ready match is never forwarded past a younger unready one.
  - No match: hit=0, stall=0, data=0.
- Register 0 is an ordinary register with no special casing.
- Writeback: wb_valid/wb_rt/wb_data mirror stage DEPTH-1. Both pipes may write the same rt in one cycle; the register file gives priority to the higher pipe, and this block does not merge them.
- Flush=1 at an edge: stage 0 loads invalid (incoming dropped), and stages 1..FLUSH_DEPTH-1 load invalid after the shift. Older stages shift normally.
- Reset low at an edge: all valid bits cleared; reset wins over flush and issue. Data and rt registers need no reset.
- Reset values of outputs: wb_valid=0, fwd_hit=0, fwd_stall=0, fwd_data=0, wb_rt/wb_data don't-care, gated by wb_valid=0.

## Timing
- Issue sampled at edge t: entry is in stage 0 after t, and visible to lookups in cycle t+1.
- Entry reaches writeback in cycle t+DEPTH, i.e. DEPTH edges after issue.
- Forwarding becomes available in cycle t+lat; fwd_stall is asserted for cycles t+1..t+lat-1.
- Lookups are purely combinational from registered state, with no same-cycle bypass of in_*.
- Writeback outputs come directly from registers with no combinational path from inputs.

## Structure
- Package spu_fwd_pkg holds:
  - the fwd_entry_t struct (valid, rt, data, lat);
  - constants for the default DATA_W, ADDR_W and LAT_W;
  - the clamp_lat function.
- Sub-module spu_fwd_lookup: one combinational priority match per (pipe, source), parametrised by NPIPE and DEPTH, instantiated NPIPE*NSRC times.
- Top level: the staging shift register, the flush/reset mask, and the writeback taps.

## Test plan
- Reset low 1 cycle with in_valid=11 -> all outputs 0; lookups on any address give hit=0, stall=0.
- Issue pipe0 rt=5, data=0xA5, lat=2 at edge t; lookup src=5 -> stall=1 in cycle t+1, hit=1 with data 0xA5 in cycles t+2..t+7; wb_valid[0]=1 with rt=5 in cycle t+7.
- Same edge: pipe0 rt=2, data=1, lat=1 and pipe1 rt=2, data=2, lat=1 -> lookup src=2 returns 2. Next edge issue pipe0 rt=2, data=3, lat=4 -> stall=1, not data 2, until that entry is ready.
- Issue rt=9, lat=1 at edge t, then flush at edge t+1 -> the entry is dropped from stage 1; lookup src=9 misses and no writeback occurs. An entry issued at t-2 survives and writes back.
- Reset low asserted mid-flight while 6 entries are valid -> the next cycle has no hits and no writeback; issue resumes normally after reset returns high.
- in_lat=0 and in_lat=7 with DEPTH=7 -> ready in stage 0 and stage 6 respectively, never later.
